// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory fetch bus shared by the IF stage and the instruction memory.
//
// Handshake: the master raises imem_req with imem_addr and holds both stable
// until a cycle in which imem_ack=1. imem_rdata is valid only in that cycle.
// imem_ack may be high in the same cycle imem_req rises (zero-wait memory).
// imem_ack is ignored whenever imem_req=0.
//
// Signals:
//   imem_req    master -> slave   fetch request
//   imem_addr   master -> slave   word-aligned fetch address
//   imem_ack    slave  -> master  imem_rdata valid this cycle
//   imem_rdata  slave  -> master  instruction word
interface fetch_pc_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_pc_unit.sv
// IF stage: owns the PC, fetches instruction words over the imem req/ack bus
// and loads the IF/ID pipeline register. Takes jump redirects from ID and
// taken-branch redirects from EX, honours hazard stalls and bubbles every
// wrong-path fetch so IF/ID never carries one.
//
// Optional feature macro: DELAY_SLOT_EN
//   defined   - a jump lets the word already in flight (or held) complete
//               into IF/ID as a delay slot; branches still flush.
//   undefined - a jump flushes exactly like a taken branch.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   stall_i           hazard stall: freeze IF/ID and the PC
//   jump_i, j_addr_i  jump redirect from ID and its target
//   branch_taken_i,
//   branch_addr_i     taken branch from EX and its target (beats jump)
//   imem              fetch bus (master side)
//   if_id_pc_o        PC of the instruction in IF/ID
//   if_id_pc4_o       if_id_pc_o + 4
//   if_id_instr_o     instruction word in IF/ID
//   if_id_valid_o     IF/ID holds a live instruction
//   state_o           FSM state (0 = FETCH, 1 = HOLD)
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   jump_i,
  input  logic [31:0]            j_addr_i,
  input  logic                   branch_taken_i,
  input  logic [31:0]            branch_addr_i,
  fetch_pc_unit_if.master        imem,
  output logic [31:0]            if_id_pc_o,
  output logic [31:0]            if_id_pc4_o,
  output logic [31:0]            if_id_instr_o,
  output logic                   if_id_valid_o,
  output logic                   state_o
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_e;

  localparam logic [31:0] RESET_PC_A = RESET_PC & 32'hFFFF_FFFC;

  state_e      state_q;
  logic        req_q;
  logic [31:0] pc_q;
  logic        pend_q;         // redirect latched while a fetch is outstanding
  logic        pend_squash_q;  // that redirect kills the outstanding word
  logic [31:0] pend_addr_q;
  logic [31:0] hold_instr_q;   // word accepted under stall; its PC is pc_q
  logic [31:0] if_id_pc_q;
  logic [31:0] if_id_pc4_q;
  logic [31:0] if_id_instr_q;
  logic        if_id_valid_q;

  logic        jmp_eff;
  logic        redir;
  logic [31:0] redir_tgt;
  logic        redir_squash;
  logic        word_ok;
  logic [31:0] pc_plus4;
  logic        discard;
  logic        take_tgt;
  logic [31:0] next_tgt;

  always_comb begin
    jmp_eff   = jump_i & ~stall_i;
    redir     = branch_taken_i | jmp_eff;
    redir_tgt = branch_taken_i ? (branch_addr_i & 32'hFFFF_FFFC)
                               : (j_addr_i & 32'hFFFF_FFFC);
`ifdef DELAY_SLOT_EN
    redir_squash = branch_taken_i;
`else
    redir_squash = redir;
`endif
    word_ok  = req_q & imem.imem_ack;
    pc_plus4 = pc_q + 32'd4;
    // A returning word is wrong-path if this cycle's redirect squashes it or
    // an earlier squashing redirect is still pending against it.
    discard  = redir_squash | (pend_q & pend_squash_q);
    take_tgt = redir | pend_q;
    next_tgt = redir ? redir_tgt : pend_addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH;
      req_q         <= 1'b0;
      pc_q          <= RESET_PC_A;
      pend_q        <= 1'b0;
      pend_squash_q <= 1'b0;
      pend_addr_q   <= 32'h0;
      hold_instr_q  <= 32'h0;
      if_id_pc_q    <= 32'h0;
      if_id_pc4_q   <= 32'h0;
      if_id_instr_q <= 32'h0;
      if_id_valid_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (word_ok) begin
            if (discard) begin
              if_id_valid_q <= 1'b0;
              pc_q          <= next_tgt;
              pend_q        <= 1'b0;
              pend_squash_q <= 1'b0;
            end else if (stall_i) begin
              // Keep any non-squashing pending target; it applies on exit.
              hold_instr_q <= imem.imem_rdata;
              state_q      <= HOLD;
              req_q        <= 1'b0;
            end else begin
              if_id_pc_q    <= pc_q;
              if_id_pc4_q   <= pc_plus4;
              if_id_instr_q <= imem.imem_rdata;
              if_id_valid_q <= 1'b1;
              pc_q          <= take_tgt ? next_tgt : pc_plus4;
              pend_q        <= 1'b0;
              pend_squash_q <= 1'b0;
            end
          end else begin
            req_q <= 1'b1;
            if (redir) begin
              if (req_q) begin
                // Address must stay stable until the outstanding ack.
                pend_q        <= 1'b1;
                pend_addr_q   <= redir_tgt;
                pend_squash_q <= (pend_q & pend_squash_q) | redir_squash;
              end else begin
                pc_q <= redir_tgt;
              end
            end
            if (!stall_i || branch_taken_i) if_id_valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (branch_taken_i) begin
            if_id_valid_q <= 1'b0;
            pc_q          <= redir_tgt;
            pend_q        <= 1'b0;
            pend_squash_q <= 1'b0;
            state_q       <= FETCH;
            req_q         <= 1'b1;
          end else if (!stall_i) begin
            pend_q        <= 1'b0;
            pend_squash_q <= 1'b0;
            state_q       <= FETCH;
            req_q         <= 1'b1;
            if (jump_i && redir_squash) begin
              if_id_valid_q <= 1'b0;
              pc_q          <= redir_tgt;
            end else begin
              if_id_pc_q    <= pc_q;
              if_id_pc4_q   <= pc_plus4;
              if_id_instr_q <= hold_instr_q;
              if_id_valid_q <= 1'b1;
              pc_q          <= jump_i ? redir_tgt : (pend_q ? pend_addr_q : pc_plus4);
            end
          end
        end
        default: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign if_id_pc_o     = if_id_pc_q;
  assign if_id_pc4_o    = if_id_pc4_q;
  assign if_id_instr_o  = if_id_instr_q;
  assign if_id_valid_o  = if_id_valid_q;
  assign state_o        = state_q;

endmodule
